// File: rtl/text_ctrl.sv
// Text-mode controller: character buffer, cursor/scroll sequencing and a 2-stage scan path for the glyph renderer.
// Optional blinking underline cursor is enabled by defining TEXT_CURSOR_EN.
//
// state   | meaning
// CLR_ALL | fill the whole buffer with spaces after reset
// IDLE    | accept characters from the source
// CLR_ROW | blank the new bottom row after a scroll
module text_ctrl #(
    parameter int COLS      = 80,
    parameter int ROWS      = 60,
    parameter int CELL_LOG2 = 3
`ifdef TEXT_CURSOR_EN
    ,
    parameter int BLINK_FRAMES = 30
`endif
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_ascii,
    input  logic [9:0] h_addr,
    input  logic [9:0] v_addr,
    input  logic       scan_valid,
    output logic [7:0] ascii,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [6:0] cursor_col,
    output logic [5:0] cursor_row,
    output logic       cursor_on
);
    localparam int NCELL = COLS * ROWS;
    localparam int AW    = $clog2(NCELL);

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

    state_t          r_state, w_state_nxt;
    logic [6:0]      r_col, w_col_nxt;
    logic [5:0]      r_row, w_row_nxt;
    logic [5:0]      r_top, w_top_nxt;
    logic [AW-1:0]   r_cnt, w_cnt_nxt;
    logic [AW-1:0]   r_clr_addr, w_clr_addr_nxt;
    logic            w_we;
    logic            w_adv;
    logic [AW-1:0]   w_waddr;
    logic [7:0]      w_wdata;

    logic [7:0]      r_mem [NCELL];
    logic [7:0]      r_rd_data;

    logic [6:0]      w_scol;
    logic [6:0]      w_srow;
    logic            w_cur_hit;
    logic            r_s1_valid, r_s2_valid;
    logic [AW-1:0]   r_s1_addr;
    logic [CELL_LOG2-1:0] r_s1_x, r_s1_y, r_s2_x, r_s2_y;
    logic            r_s1_cur, r_s2_cur;

    // Logical row is rotated by top so a scroll never moves buffer contents.
    function automatic logic [AW-1:0] f_addr(input logic [5:0] top, input logic [6:0] row,
                                             input logic [6:0] col);
        logic [7:0] phys;
        phys = 8'(top) + 8'(row);
        if (phys >= 8'(ROWS))
            phys = phys - 8'(ROWS);
        return AW'(int'(phys) * COLS + int'(col));
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= CLR_ALL;
            r_col      <= '0;
            r_row      <= '0;
            r_top      <= '0;
            r_cnt      <= AW'(NCELL - 1);
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_top      <= w_top_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_top_nxt      = r_top;
        w_cnt_nxt      = r_cnt;
        w_clr_addr_nxt = r_clr_addr;
        w_we           = 1'b0;
        w_adv          = 1'b0;
        w_waddr        = r_clr_addr;
        w_wdata        = 8'h20;
        case (r_state)
            CLR_ALL, CLR_ROW: begin
                w_we           = 1'b1;
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                w_cnt_nxt      = r_cnt - 1'b1;
                if (r_cnt == '0)
                    w_state_nxt = IDLE;
            end
            IDLE: begin
                if (wr_valid) begin
                    if (wr_ascii >= 8'h20 && wr_ascii <= 8'h7E) begin
                        w_we    = 1'b1;
                        w_waddr = f_addr(r_top, {1'b0, r_row}, r_col);
                        w_wdata = wr_ascii;
                        if (r_col == 7'(COLS - 1)) begin
                            w_col_nxt = '0;
                            w_adv     = 1'b1;
                        end else begin
                            w_col_nxt = r_col + 7'd1;
                        end
                    end else if (wr_ascii == 8'h0A || wr_ascii == 8'h0D) begin
                        w_col_nxt = '0;
                        w_adv     = 1'b1;
                    end else if (wr_ascii == 8'h08) begin
                        if (r_col != '0) begin
                            w_col_nxt = r_col - 7'd1;
                            w_we      = 1'b1;
                            w_waddr   = f_addr(r_top, {1'b0, r_row}, r_col - 7'd1);
                        end else if (r_row != '0) begin
                            w_col_nxt = 7'(COLS - 1);
                            w_row_nxt = r_row - 6'd1;
                            w_we      = 1'b1;
                            w_waddr   = f_addr(r_top, {1'b0, r_row - 6'd1}, 7'(COLS - 1));
                        end
                    end
                end
            end
            default: w_state_nxt = CLR_ALL;
        endcase
        if (w_adv) begin
            if (r_row < 6'(ROWS - 1)) begin
                w_row_nxt = r_row + 6'd1;
            end else begin
                // The old top physical row becomes the new bottom row and is blanked.
                w_top_nxt      = (r_top == 6'(ROWS - 1)) ? 6'd0 : r_top + 6'd1;
                w_state_nxt    = CLR_ROW;
                w_cnt_nxt      = AW'(COLS - 1);
                w_clr_addr_nxt = AW'(int'(r_top) * COLS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        r_rd_data <= r_mem[r_s1_addr];
    end

    assign w_scol = 7'(h_addr >> CELL_LOG2);
    assign w_srow = 7'(v_addr >> CELL_LOG2);

`ifdef TEXT_CURSOR_EN
    logic [9:0] r_v_prev;
    logic [7:0] r_frame_cnt;
    logic       r_blink_off;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_v_prev    <= '0;
            r_frame_cnt <= '0;
            r_blink_off <= 1'b0;
        end else begin
            r_v_prev <= v_addr;
            if (r_v_prev == 10'd479 && v_addr == 10'd0) begin
                if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    r_blink_off <= ~r_blink_off;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    assign w_cur_hit = scan_valid && !r_blink_off && (w_scol == r_col) &&
                       (w_srow == {1'b0, r_row}) &&
                       (v_addr[CELL_LOG2-1:0] == CELL_LOG2'(6));
`else
    assign w_cur_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_cur   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_x     <= '0;
            r_s2_y     <= '0;
            r_s2_cur   <= 1'b0;
        end else begin
            r_s1_valid <= scan_valid;
            r_s1_addr  <= f_addr(r_top, w_srow, w_scol);
            r_s1_x     <= scan_valid ? h_addr[CELL_LOG2-1:0] : '0;
            r_s1_y     <= scan_valid ? v_addr[CELL_LOG2-1:0] : '0;
            r_s1_cur   <= w_cur_hit;
            r_s2_valid <= r_s1_valid;
            r_s2_x     <= r_s1_x;
            r_s2_y     <= r_s1_y;
            r_s2_cur   <= r_s1_cur;
        end
    end

    assign wr_ready   = (r_state == IDLE);
    assign ascii      = r_s2_valid ? r_rd_data : 8'h00;
    assign x          = 10'(r_s2_x);
    assign y          = 10'(r_s2_y);
    assign cursor_on  = r_s2_cur;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
endmodule

// File: tb/tb_text_ctrl.sv
// Self-checking bench for text_ctrl (default build): screen model with row-shift scrolling, random text and random scan pixels.
module tb_text_ctrl;
    logic       clk = 1'b0;
    logic       clr;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_ascii;
    logic [9:0] h_addr;
    logic [9:0] v_addr;
    logic       scan_valid;
    logic [7:0] ascii;
    logic [9:0] x;
    logic [9:0] y;
    logic [6:0] cursor_col;
    logic [5:0] cursor_row;
    logic       cursor_on;

    text_ctrl dut (
        .clk(clk), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ascii(wr_ascii),
        .h_addr(h_addr), .v_addr(v_addr), .scan_valid(scan_valid), .ascii(ascii),
        .x(x), .y(y), .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_on(cursor_on)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Screen model in logical rows; a scroll literally shifts rows up.
    logic [7:0] scr [60][80];
    int mcol, mrow;

    function automatic void model_reset();
        for (int r = 0; r < 60; r++)
            for (int c = 0; c < 80; c++)
                scr[r][c] = 8'h20;
        mcol = 0;
        mrow = 0;
    endfunction

    function automatic void model_adv();
        if (mrow < 59) begin
            mrow++;
        end else begin
            for (int r = 0; r < 59; r++)
                for (int c = 0; c < 80; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < 80; c++)
                scr[59][c] = 8'h20;
        end
    endfunction

    function automatic void model_apply(input logic [7:0] code);
        if (code >= 8'h20 && code <= 8'h7E) begin
            scr[mrow][mcol] = code;
            if (mcol == 79) begin
                mcol = 0;
                model_adv();
            end else begin
                mcol++;
            end
        end else if (code == 8'h0A || code == 8'h0D) begin
            mcol = 0;
            model_adv();
        end else if (code == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                scr[mrow][mcol] = 8'h20;
            end else if (mrow > 0) begin
                mcol = 79;
                mrow--;
                scr[mrow][mcol] = 8'h20;
            end
        end
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [9:0] ex;
        logic [9:0] ey;
    } exp_t;
    exp_t q[$];

    task automatic scan_step(input int h, input int v, input bit sv);
        exp_t e;
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("scan_ascii", ascii, e.a);
            chk("scan_x", x, e.ex);
            chk("scan_y", y, e.ey);
            chk("cursor_on", cursor_on, 0);
        end
        e.a  = sv ? scr[v/8][h/8] : 8'h00;
        e.ex = sv ? 10'(h % 8) : 10'd0;
        e.ey = sv ? 10'(v % 8) : 10'd0;
        q.push_back(e);
        h_addr     = 10'(h);
        v_addr     = 10'(v);
        scan_valid = sv;
        @(negedge clk);
    endtask

    task automatic scan_flush();
        scan_step(0, 0, 1'b0);
        scan_step(0, 0, 1'b0);
        q.delete();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) chk("ready_timeout", wr_ready, 1);
    endtask

    task automatic send(input logic [7:0] code);
        int n = 0;
        wr_valid = 1'b1;
        wr_ascii = code;
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) chk("send_timeout", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        model_apply(code);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_col"}, cursor_col, mcol);
        chk({tag, "_row"}, cursor_row, mrow);
    endtask

    task automatic random_scan(input int n);
        wait_ready();
        repeat (n) scan_step($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 7) != 0);
        scan_flush();
    endtask

    task automatic count_clear();
        int n = 0;
        while (!wr_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("clear_cycles", n, 4800);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        logic [7:0] code;
        clr = 1'b1;
        wr_valid = 1'b0;
        wr_ascii = 8'h00;
        h_addr = '0;
        v_addr = '0;
        scan_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", wr_ready, 0);
        chk("rst_ascii", ascii, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_cursor_on", cursor_on, 0);
        chk("rst_col", cursor_col, 0);
        chk("rst_row", cursor_row, 0);

        wr_valid = 1'b1;
        clr = 1'b0;
        count_clear();
        wr_valid = 1'b0;
        model_reset();
        random_scan(300);

        send(8'h08);
        chk_cursor("bs_origin");
        send(8'h41);
        chk_cursor("after_A");
        for (int h = 0; h <= 8; h++) scan_step(h, 3, 1'b1);
        scan_flush();
        send(8'h08);
        chk_cursor("bs_A");
        for (int h = 0; h < 8; h++) scan_step(h, 0, 1'b1);
        scan_flush();

        repeat (80) send(8'h42);
        chk_cursor("row_wrap");
        for (int h = 632; h < 640; h++) scan_step(h, 2, 1'b1);
        scan_flush();
        send(8'h58); send(8'h59); send(8'h5A);
        while (mrow < 5) send(8'h0A);
        send(8'h08);
        chk_cursor("bs_col0");
        for (int h = 632; h < 640; h++) scan_step(h, 37, 1'b1);
        scan_flush();

        while (mrow < 59) send(8'h0A);
        send(8'h0A);
        n = 0;
        while (!wr_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk("scroll_busy", n, 80);
        chk_cursor("scroll");
        for (int h = 0; h < 32; h++) scan_step(h, 1, 1'b1);
        for (int h = 0; h < 640; h += 7) scan_step(h, 472 + (h % 8), 1'b1);
        scan_flush();
        random_scan(400);

        for (int i = 0; i < 1200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      code = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 80) code = 8'h0A;
            else if (r < 85) code = 8'h0D;
            else if (r < 95) code = 8'h08;
            else             code = (r < 97) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(8'h7F, 8'hFF));
            send(code);
            if (i % 100 == 99) begin
                wait_ready();
                chk_cursor("rand");
                random_scan(100);
            end
        end

        wait_ready();
        while (mrow < 59) send(8'h0A);
        h_addr = 10'd5;
        v_addr = 10'd5;
        scan_valid = 1'b1;
        send(8'h0A);
        repeat (10) @(negedge clk);
        chk("pre_clr_x", x, 5);
        chk("pre_clr_y", y, 5);
        chk("pre_clr_ready", wr_ready, 0);
        clr = 1'b1;
        #1;
        chk("clr_ready", wr_ready, 0);
        chk("clr_ascii", ascii, 0);
        chk("clr_x", x, 0);
        chk("clr_y", y, 0);
        chk("clr_col", cursor_col, 0);
        chk("clr_row", cursor_row, 0);
        @(negedge clk);
        scan_valid = 1'b0;
        clr = 1'b0;
        count_clear();
        model_reset();
        chk_cursor("post_clr");
        for (int h = 0; h < 16; h++) scan_step(h, 0, 1'b1);
        scan_flush();
        random_scan(300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
